// File: rtl/cfu_cmd_initiator.sv
// Host-side CFU command initiator: issues one tagless command at a time, waits for the
// response (or a watchdog expiry) and queues results in a small first-word-fall-through FIFO.
module cfu_cmd_initiator #(
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        timeout_err,
  input  logic        clear_err,
  output logic        busy,
  output logic [15:0] issued_count
);

  localparam int unsigned AW  = $clog2(RSP_DEPTH);
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q;
  logic          cmd_valid_q;
  logic [9:0]    fid_q;
  logic [31:0]   in0_q, in1_q;
  logic [WdW-1:0] wdog_q;
  logic [15:0]   issued_q;
  logic          err_q;

  logic [32:0]   mem_q [RSP_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic        fifo_full, fifo_empty;
  logic        req_fire, cmd_fire, rsp_fire;
  logic        wd_expired, timeout_fire;
  logic        push, pop;
  logic [32:0] push_data, head;

  assign fifo_full  = (count_q == (AW+1)'(RSP_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign req_ready = reset_n & (state_q == StIdle) & ~fifo_full;
  assign req_fire  = req_valid & req_ready;
  assign cmd_fire  = (state_q == StIssue) & cmd_ready;
  assign rsp_fire  = (state_q == StWait) & rsp_valid;

  // Counter saturates at TIMEOUT-1; a handshake in the expiry cycle beats the timeout.
  assign wd_expired   = (TIMEOUT != 0) && (wdog_q == WdW'(TIMEOUT - 1));
  assign timeout_fire = (state_q != StIdle) & wd_expired & ~cmd_fire & ~rsp_fire;

  assign push      = rsp_fire | timeout_fire;
  assign push_data = {timeout_fire, rsp_fire ? rsp_payload_outputs_0 : 32'h0};
  assign pop       = res_ready & ~fifo_empty;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      wdog_q      <= '0;
      issued_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_fire) begin
            fid_q       <= req_function_id;
            in0_q       <= req_inputs_0;
            in1_q       <= req_inputs_1;
            cmd_valid_q <= 1'b1;
            wdog_q      <= '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (cmd_fire) begin
            issued_q    <= issued_q + 16'd1;
            cmd_valid_q <= 1'b0;
            state_q     <= StWait;
          end else if (timeout_fire) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StWait: begin
          if (rsp_fire || timeout_fire) state_q <= StIdle;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
      if (state_q != StIdle && !wd_expired) wdog_q <= wdog_q + WdW'(1);
      if (timeout_fire)   err_q <= 1'b1;
      else if (clear_err) err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign cmd_valid               = cmd_valid_q;
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign rsp_ready               = (state_q == StWait);
  assign res_valid               = ~fifo_empty;
  assign res_data                = fifo_empty ? 32'h0 : head[31:0];
  assign res_timeout             = ~fifo_empty & head[32];
  assign timeout_err             = err_q;
  assign busy                    = (state_q != StIdle) | ~fifo_empty;
  assign issued_count            = issued_q;

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Directed testbench for cfu_cmd_initiator (RSP_DEPTH=4, TIMEOUT=8).
module tb_cfu_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_function_id = '0;
  logic [31:0] req_inputs_0 = '0;
  logic [31:0] req_inputs_1 = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        timeout_err;
  logic        clear_err = 1'b0;
  logic        busy;
  logic [15:0] issued_count;

  int errs = 0;
  int checks = 0;

  cfu_cmd_initiator #(.RSP_DEPTH(4), .TIMEOUT(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_function_id         (req_function_id),
    .req_inputs_0            (req_inputs_0),
    .req_inputs_1            (req_inputs_1),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_timeout             (res_timeout),
    .timeout_err             (timeout_err),
    .clear_err               (clear_err),
    .busy                    (busy),
    .issued_count            (issued_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: req accepted, cmd handshake next cycle, response the cycle after.
  task automatic do_txn(input logic [9:0] id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r);
    req_valid = 1'b1; req_function_id = id; req_inputs_0 = a; req_inputs_1 = b;
    step();
    req_valid = 1'b0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_payload_outputs_0 = r;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (rsp_ready !== 1'b0) begin errs++; $display("FAIL rst_rsp_ready: got %b want 0", rsp_ready); end
    checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    checks++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0 || res_timeout !== 1'b0) begin
      errs++; $display("FAIL rst_flags: got busy=%b err=%b rto=%b want 0 0 0", busy, timeout_err, res_timeout); end
    checks++; if (issued_count !== 16'd0 || res_data !== 32'd0) begin
      errs++; $display("FAIL rst_counts: got issued=%0d data=%h want 0 0", issued_count, res_data); end
    checks++; if (cmd_payload_function_id !== 10'd0 || cmd_payload_inputs_0 !== 32'd0 ||
                  cmd_payload_inputs_1 !== 32'd0) begin
      errs++; $display("FAIL rst_payload: got %h %h %h want zeros", cmd_payload_function_id,
                       cmd_payload_inputs_0, cmd_payload_inputs_1); end
    step(); step();
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_release_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_function_id = 10'h008; req_inputs_0 = 32'd3; req_inputs_1 = 32'd4;
    step();
    req_valid = 1'b0;
    checks++; if (cmd_valid !== 1'b1) begin errs++; $display("FAIL single_cmd_valid: got %b want 1", cmd_valid); end
    checks++; if (cmd_payload_function_id !== 10'h008 || cmd_payload_inputs_0 !== 32'd3 ||
                  cmd_payload_inputs_1 !== 32'd4) begin
      errs++; $display("FAIL single_payload: got %h %h %h want 008 3 4", cmd_payload_function_id,
                       cmd_payload_inputs_0, cmd_payload_inputs_1); end
    checks++; if (req_ready !== 1'b0 || rsp_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL single_issue_flags: got rq=%b rs=%b busy=%b want 0 0 1", req_ready, rsp_ready, busy); end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || rsp_ready !== 1'b1) begin
      errs++; $display("FAIL single_wait: got cv=%b rs=%b want 0 1", cmd_valid, rsp_ready); end
    checks++; if (issued_count !== 16'd1) begin errs++; $display("FAIL single_issued: got %0d want 1", issued_count); end
    step();
    rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'd7;
    step();
    rsp_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd7 || res_timeout !== 1'b0) begin
      errs++; $display("FAIL single_result: got v=%b d=%h to=%b want 1 7 0", res_valid, res_data, res_timeout); end
    checks++; if (req_ready !== 1'b1 || rsp_ready !== 1'b0) begin
      errs++; $display("FAIL single_idle: got rq=%b rs=%b want 1 0", req_ready, rsp_ready); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL single_pop: got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_function_id = 10'h3FF;
    req_inputs_0 = 32'hDEADBEEF; req_inputs_1 = 32'h12345678;
    step();
    req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cmd_ready = 1'b1;
      checks++; if (cmd_valid !== 1'b1 || cmd_payload_function_id !== 10'h3FF ||
                    cmd_payload_inputs_0 !== 32'hDEADBEEF || cmd_payload_inputs_1 !== 32'h12345678 ||
                    issued_count !== 16'd1) begin
        errs++; $display("FAIL bp_hold_%0d: got cv=%b %h %h %h n=%0d want 1 3ff deadbeef 12345678 1", i,
                         cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
                         cmd_payload_inputs_1, issued_count); end
      step();
    end
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || issued_count !== 16'd2) begin
      errs++; $display("FAIL bp_handshake: got cv=%b n=%0d want 0 2", cmd_valid, issued_count); end
    rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hCAFEF00D;
    step();
    rsp_valid = 1'b0;
    checks++; if (res_data !== 32'hCAFEF00D) begin errs++; $display("FAIL bp_result: got %h want cafef00d", res_data); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) do_txn(10'(i), 32'(i), 32'(i + 1), 32'h100 + 32'(i));
    checks++; if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_data !== 32'h100) begin
      errs++; $display("FAIL full_state: got v=%b rq=%b d=%h want 1 0 100", res_valid, req_ready, res_data); end
    req_valid = 1'b1; req_function_id = 10'h004; req_inputs_0 = 32'd4; req_inputs_1 = 32'd5;
    step();
    checks++; if (cmd_valid !== 1'b0 || req_ready !== 1'b0) begin
      errs++; $display("FAIL full_blocked: got cv=%b rq=%b want 0 0", cmd_valid, req_ready); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL full_after_pop: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0; cmd_ready = 1'b1;
    checks++; if (cmd_valid !== 1'b1 || cmd_payload_function_id !== 10'h004) begin
      errs++; $display("FAIL full_fifth_issue: got cv=%b id=%h want 1 004", cmd_valid, cmd_payload_function_id); end
    step();
    cmd_ready = 1'b0; rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h104;
    step();
    rsp_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 32'h100 + 32'(i)) begin
        errs++; $display("FAIL full_order_%0d: got v=%b d=%h want 1 %h", i, res_valid, res_data,
                         32'h100 + 32'(i)); end
      step();
    end
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || issued_count !== 16'd7) begin
      errs++; $display("FAIL full_drained: got v=%b n=%0d want 0 7", res_valid, issued_count); end
  endtask

  task automatic test_timeout();
    // Timeout in WAIT: handshake taken, response never comes.
    req_valid = 1'b1; req_function_id = 10'h055;
    step();
    req_valid = 1'b0; cmd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      cmd_ready = 1'b0;
    end
    checks++; if (res_valid !== 1'b0 || rsp_ready !== 1'b1 || timeout_err !== 1'b0) begin
      errs++; $display("FAIL to_before: got v=%b rs=%b err=%b want 0 1 0", res_valid, rsp_ready, timeout_err); end
    step();
    checks++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 32'd0) begin
      errs++; $display("FAIL to_entry: got v=%b to=%b d=%h want 1 1 0", res_valid, res_timeout, res_data); end
    checks++; if (timeout_err !== 1'b1 || rsp_ready !== 1'b0 || issued_count !== 16'd8) begin
      errs++; $display("FAIL to_flags: got err=%b rs=%b n=%0d want 1 0 8", timeout_err, rsp_ready, issued_count); end
    res_ready = 1'b1; clear_err = 1'b1;
    step();
    res_ready = 1'b0; clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0 || res_valid !== 1'b0) begin
      errs++; $display("FAIL to_clear: got err=%b v=%b want 0 0", timeout_err, res_valid); end
    // Timeout in ISSUE: CFU never takes the command; clear_err collides with the expiry.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (cmd_valid !== 1'b1 || res_valid !== 1'b0) begin
      errs++; $display("FAIL to2_before: got cv=%b v=%b want 1 0", cmd_valid, res_valid); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b1 || cmd_valid !== 1'b0 || res_timeout !== 1'b1) begin
      errs++; $display("FAIL to2_collide: got err=%b cv=%b to=%b want 1 0 1", timeout_err, cmd_valid, res_timeout); end
    checks++; if (issued_count !== 16'd8) begin errs++; $display("FAIL to2_issued: got %0d want 8", issued_count); end
    clear_err = 1'b1; res_ready = 1'b1;
    step();
    clear_err = 1'b0; res_ready = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to2_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_race();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++; if (res_valid !== 1'b0 || rsp_ready !== 1'b1) begin
      errs++; $display("FAIL race_before: got v=%b rs=%b want 0 1", res_valid, rsp_ready); end
    rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h55AA;
    step();
    rsp_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_data !== 32'h55AA) begin
      errs++; $display("FAIL race_result: got v=%b to=%b d=%h want 1 0 55aa", res_valid, res_timeout, res_data); end
    checks++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL race_err: got %b want 0", timeout_err); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_txn(10'h001, 32'd1, 32'd2, 32'hABCD);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++; if (rsp_ready !== 1'b1 || res_valid !== 1'b1 || issued_count !== 16'd11) begin
      errs++; $display("FAIL mid_before: got rs=%b v=%b n=%0d want 1 1 11", rsp_ready, res_valid, issued_count); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0 || rsp_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_async: got cv=%b rs=%b v=%b busy=%b want 0 0 0 0", cmd_valid, rsp_ready,
                       res_valid, busy); end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (issued_count !== 16'd0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errs++; $display("FAIL mid_release: got n=%0d rq=%b v=%b want 0 1 0", issued_count, req_ready, res_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fifo_full();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
